// File: rtl/addsub_issuer.sv
// addsub_issuer: initiator for the sign-magnitude add/sub unit.
// Takes two's-complement operands over valid/ready, issues magnitudes plus
// a sign control code with a one-cycle start pulse, waits for finish (with a
// watchdog), and returns the low 32 bits of the signed result with overflow.
module addsub_issuer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_sub,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_ovf,
   output logic        resp_timeout,
   output logic [31:0] au_a,
   output logic [31:0] au_b,
   output logic [3:0]  au_control,
   output logic        au_start,
   input  logic        au_finish,
   input  logic        au_sign,
   input  logic [31:0] au_c
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] wait_cnt;

   logic        accept;
   logic        finish_take;
   logic        timeout_hit;
   logic        response_taken;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        sign_a;
   logic        sign_b;

   // Operand conversion: magnitude plus effective sign; a zero magnitude is
   // always issued as positive so 0-0 yields the PP code.
   always_comb begin
      mag_a  = req_a[31] ? (~req_a + 32'd1) : req_a;
      mag_b  = req_b[31] ? (~req_b + 32'd1) : req_b;
      sign_a = req_a[31] & (|mag_a);
      sign_b = (req_b[31] ^ req_sub) & (|mag_b);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and handshake outputs; finish has priority over the timeout.
   always_comb begin
      state_nx       = state;
      req_ready      = 1'b0;
      au_start       = 1'b0;
      resp_valid     = 1'b0;
      accept         = 1'b0;
      finish_take    = 1'b0;
      timeout_hit    = 1'b0;
      response_taken = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept   = 1'b1;
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            au_start = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (au_finish) begin
               finish_take = 1'b1;
               state_nx    = S_DONE;
            end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_nx    = S_DONE;
            end
         end
         S_DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               response_taken = 1'b1;
               state_nx       = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Unit-side operand registers: loaded on accept, cleared on entering DONE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         au_a       <= '0;
         au_b       <= '0;
         au_control <= '0;
      end else if (accept) begin
         au_a       <= mag_a;
         au_b       <= mag_b;
         au_control <= {2'b10, sign_a, sign_b};
      end else if (finish_take || timeout_hit) begin
         au_a       <= '0;
         au_b       <= '0;
         au_control <= '0;
      end
   end

   // Watchdog counter: cleared while issuing, counts every WAIT cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (state == S_ISSUE) begin
         wait_cnt <= '0;
      end else if (state == S_WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Response registers: captured when WAIT exits, held through DONE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         resp_result  <= '0;
         resp_ovf     <= 1'b0;
         resp_timeout <= 1'b0;
      end else if (finish_take) begin
         resp_result  <= au_c;
         resp_ovf     <= au_sign ^ au_c[31];
         resp_timeout <= 1'b0;
      end else if (timeout_hit) begin
         resp_result  <= '0;
         resp_ovf     <= 1'b0;
         resp_timeout <= 1'b1;
      end else if (response_taken) begin
         resp_result  <= '0;
         resp_ovf     <= 1'b0;
         resp_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_addsub_issuer.sv
// tb_addsub_issuer: directed bench acting as both requester and add/sub unit.
module tb_addsub_issuer;

   localparam int unsigned TO = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        req_sub = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_result;
   logic        resp_ovf;
   logic        resp_timeout;
   logic [31:0] au_a;
   logic [31:0] au_b;
   logic [3:0]  au_control;
   logic        au_start;
   logic        au_finish = 1'b0;
   logic        au_sign = 1'b0;
   logic [31:0] au_c = '0;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        to;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   fails = 0;

   addsub_issuer #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_ovf(resp_ovf), .resp_timeout(resp_timeout),
      .au_a(au_a), .au_b(au_b), .au_control(au_control), .au_start(au_start),
      .au_finish(au_finish), .au_sign(au_sign), .au_c(au_c)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction; fin_cyc = cycle after accept in which finish is
   // driven (0 = never), bp = cycles of response backpressure.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input int fin_cyc, input int bp);
      logic [32:0] sum;
      logic [31:0] ma;
      logic [31:0] mb;
      logic [3:0]  ctl;
      exp_t        e;
      exp_t        got;
      int          cyc;
      int          g;
      sum = {a[31], a} + (sub ? (33'd0 - {b[31], b}) : {b[31], b});
      ma  = a[31] ? (32'd0 - a) : a;
      mb  = b[31] ? (32'd0 - b) : b;
      ctl = {2'b10, (a[31] && a != 0), ((b[31] ^ sub) && b != 0)};
      e.res = (fin_cyc == 0) ? 32'd0 : sum[31:0];
      e.ovf = (fin_cyc == 0) ? 1'b0 : (sum[32] ^ sum[31]);
      e.to  = (fin_cyc == 0);

      g = 0;
      while (req_ready !== 1'b1 && g < 20) begin
         tick();
         g++;
      end
      check("req_ready_idle", {31'd0, req_ready}, 32'd1);

      req_valid = 1'b1;
      req_a = a;
      req_b = b;
      req_sub = sub;
      sb_q.push_back(e);
      tick();
      req_valid = 1'b0;
      req_a = $urandom;
      req_b = $urandom;
      req_sub = 1'($urandom_range(0, 1));

      cyc = 1;
      while (resp_valid !== 1'b1 && cyc < 200) begin
         check("au_start", {31'd0, au_start}, {31'd0, (cyc == 1)});
         check("req_ready_busy", {31'd0, req_ready}, 32'd0);
         check("au_a", au_a, ma);
         check("au_b", au_b, mb);
         check("au_control", {28'd0, au_control}, {28'd0, ctl});
         if (cyc == fin_cyc) begin
            au_finish = 1'b1;
            au_sign = sum[32];
            au_c = sum[31:0];
         end else begin
            au_finish = 1'b0;
            au_sign = 1'($urandom_range(0, 1));
            au_c = $urandom;
         end
         tick();
         cyc++;
      end
      au_finish = 1'b0;
      check("latency", cyc, (fin_cyc == 0) ? (TO + 2) : (fin_cyc + 1));
      check("au_a_done", au_a, 32'd0);
      check("au_control_done", {28'd0, au_control}, 32'd0);

      for (int i = 0; i < bp; i++) begin
         resp_ready = 1'b0;
         au_finish = 1'($urandom_range(0, 1));
         au_c = $urandom;
         check("bp_valid", {31'd0, resp_valid}, 32'd1);
         check("bp_ready", {31'd0, req_ready}, 32'd0);
         check("bp_result", resp_result, e.res);
         check("bp_timeout", {31'd0, resp_timeout}, {31'd0, e.to});
         tick();
      end
      au_finish = 1'b0;

      check("sb_nonempty", {31'd0, (sb_q.size() > 0)}, 32'd1);
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         check("resp_result", resp_result, got.res);
         check("resp_ovf", {31'd0, resp_ovf}, {31'd0, got.ovf});
         check("resp_timeout", {31'd0, resp_timeout}, {31'd0, got.to});
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
      check("req_ready_back", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      reset = 1'b0;
      tick();
      tick();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_au_start", {31'd0, au_start}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_au_a", au_a, 32'd0);
      check("rst_au_control", {28'd0, au_control}, 32'd0);
      check("rst_result", resp_result, 32'd0);
      check("rst_timeout", {31'd0, resp_timeout}, 32'd0);
      reset = 1'b1;
      tick();

      do_op(32'd5, 32'd3, 1'b0, 4, 0);
      do_op(32'h0000_0002, 32'hFFFF_FFFD, 1'b1, 3, 10);
      do_op(32'h8000_0000, 32'd1, 1'b1, 2, 0);
      do_op(32'd0, 32'd0, 1'b1, 5, 0);
      do_op(32'hFFFF_FFF9, 32'hFFFF_FFF7, 1'b0, 2, 1);
      do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 3, 0);
      do_op(32'd3, 32'h8000_0000, 1'b1, 2, 0);
      do_op(32'h1234_5678, 32'd9, 1'b0, 0, 2);
      do_op(32'hFFFF_FF00, 32'd7, 1'b1, TO + 1, 0);

      // Spurious finish while idle must not create a response.
      au_finish = 1'b1;
      au_c = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_fin_valid", {31'd0, resp_valid}, 32'd0);
         check("idle_fin_ready", {31'd0, req_ready}, 32'd1);
      end
      au_finish = 1'b0;

      // Reset while waiting: operation is dropped, late finish ignored.
      req_valid = 1'b1;
      req_a = 32'd11;
      req_b = 32'd22;
      req_sub = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      check("mid_busy", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_start", {31'd0, au_start}, 32'd0);
      check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
      check("mid_rst_au_a", au_a, 32'd0);
      au_finish = 1'b1;
      au_c = 32'd33;
      tick();
      au_finish = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late_fin_valid", {31'd0, resp_valid}, 32'd0);
         check("late_fin_start", {31'd0, au_start}, 32'd0);
         tick();
      end

      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 6, 0);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
